// File: rtl/inst_boot_loader.sv
// Instruction RAM with a byte-stream boot loader in front of it.
// A framed image (16-bit word count, payload words LSB first, 8-bit additive
// checksum) is written into RAM. The core is held in reset until the checksum
// matches. Fetches are served combinationally from pc in every state.

`ifndef START_ADRS
`define START_ADRS 32'h0000_0000
`endif

module inst_boot_loader #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] START_ADRS = `START_ADRS
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] words_q, words_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  sum_q, sum_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem [DEPTH];

    // Full 16-bit count as it will be once the CNT_HI byte is taken.
    logic [15:0] cnt_new;
    assign cnt_new = {rx_data, count_q[7:0]};

    // Next-state logic: one byte is consumed per cycle with rx_valid high.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        words_d   = words_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        sum_d     = sum_q;
        mem_we    = 1'b0;
        mem_waddr = words_q[AW-1:0];
        mem_wdata = {rx_data, asm_q[23:0]};

        if (!reset) begin
            // Reset wins over a coincident byte; partial word and sum are discarded.
            state_d = StCntLo;
            count_d = '0;
            words_d = '0;
            idx_d   = '0;
            asm_d   = '0;
            sum_d   = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                StCntLo: begin
                    count_d[7:0] = rx_data;
                    state_d      = StCntHi;
                end
                StCntHi: begin
                    count_d[15:8] = rx_data;
                    if ({16'd0, cnt_new} > DEPTH) begin
                        state_d = StError;
                    end else if (cnt_new == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    asm_d[{idx_q, 3'b000} +: 8] = rx_data;
                    sum_d = sum_q + rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mem_we  = 1'b1;
                        words_d = words_q + 16'd1;
                        if (words_q + 16'd1 == count_q) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    state_d = (rx_data == sum_q) ? StDone : StError;
                end
                StDone, StError: begin
                    // Absorbing: bytes are ignored until reset.
                end
                default: state_d = StError;
            endcase
        end
    end

    // Loader state registers with synchronous active-low reset folded into _d.
    always_ff @(posedge clk_cpu) begin
        state_q <= state_d;
        count_q <= count_d;
        words_q <= words_d;
        idx_q   <= idx_d;
        asm_q   <= asm_d;
        sum_q   <= sum_d;
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_cpu) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [31:0] fetch_off;
    logic [31:0] fetch_idx;

    // Combinational fetch; out-of-window addresses (including wrap below base) read zero.
    always_comb begin
        fetch_off = pc - START_ADRS;
        fetch_idx = fetch_off >> 2;
        if (fetch_idx < DEPTH) begin
            inst = mem[fetch_idx[AW-1:0]];
        end else begin
            inst = 32'h0000_0000;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        load_done    = (state_q == StDone);
        load_error   = (state_q == StError);
        cpu_reset    = (state_q != StDone);
        words_loaded = words_q;
    end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Self-checking bench for inst_boot_loader: expected RAM words are queued as
// payload is sent and popped against fetched instructions afterwards.

module tb_inst_boot_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [31:0] img_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  exp_sum;

    inst_boot_loader #(
        .DEPTH      (DEPTH),
        .START_ADRS (BASE)
    ) dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .pc           (pc),
        .inst         (inst),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_cpu);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk_cpu);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk_cpu);
        #1;
        reset = 1'b1;
    endtask

    // Sends count and payload from img_q (no checksum); queues expected words.
    task automatic send_image(input int max_gap);
        logic [15:0] n;
        logic [31:0] w;
        n       = 16'(img_q.size());
        exp_sum = 8'h00;
        exp_q.delete();
        send_byte(n[7:0]);
        idle($urandom_range(0, max_gap));
        send_byte(n[15:8]);
        foreach (img_q[i]) begin
            w = img_q[i];
            exp_q.push_back(w);
            for (int b = 0; b < 4; b++) begin
                idle($urandom_range(0, max_gap));
                send_byte(w[8*b +: 8]);
                exp_sum = exp_sum + w[8*b +: 8];
            end
        end
        idle($urandom_range(0, max_gap));
    endtask

    task automatic load_nominal_words();
        img_q.delete();
        img_q.push_back(32'h0000_0013);
        img_q.push_back(32'h0010_0093);
    endtask

    task automatic test_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = BASE;
        do_reset();
        checks++;
        if ({cpu_reset, load_done, load_error} !== 3'b100 || words_loaded !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got rst/done/err=%b%b%b words=%0d, want 100 words=0",
                     cpu_reset, load_done, load_error, words_loaded);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        load_nominal_words();
        send_image(0);
        checks++;
        if (exp_sum !== 8'hB6 || words_loaded !== 16'd2 || load_done !== 1'b0
            || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL nominal_pre_csum: sum=%h words=%0d done=%b rst=%b, want b6 2 0 1",
                     exp_sum, words_loaded, load_done, cpu_reset);
        end
        send_byte(8'hB6);
        checks++;
        if ({load_done, load_error, cpu_reset} !== 3'b100) begin
            failures++;
            $display("FAIL nominal_done: done/err/rst=%b%b%b, want 100",
                     load_done, load_error, cpu_reset);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e  = exp_q.pop_front();
            pc = BASE + 32'(4 * i);
            #1;
            checks++;
            if (inst !== e) begin
                failures++;
                $display("FAIL nominal_word%0d: inst=%h, want %h", i, inst, e);
            end
        end
        pc = BASE + 32'd7;
        #1;
        checks++;
        if (inst !== 32'h0010_0093) begin
            failures++;
            $display("FAIL pc_low_bits_ignored: inst=%h, want 00100093", inst);
        end
    endtask

    task automatic test_after_done();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        pc = BASE;
        #1;
        checks++;
        if (load_done !== 1'b1 || load_error !== 1'b0 || words_loaded !== 16'd2
            || inst !== 32'h0000_0013) begin
            failures++;
            $display("FAIL after_done: done=%b err=%b words=%0d inst=%h, want 1 0 2 00000013",
                     load_done, load_error, words_loaded, inst);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        load_nominal_words();
        send_image(0);
        send_byte(exp_sum + 8'd1);
        checks++;
        if ({load_done, load_error, cpu_reset} !== 3'b011) begin
            failures++;
            $display("FAIL bad_csum: done/err/rst=%b%b%b, want 011",
                     load_done, load_error, cpu_reset);
        end
        send_byte(8'h00);
        checks++;
        if (load_error !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL error_sticky: err=%b done=%b, want 1 0", load_error, load_done);
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h04);
        checks++;
        if (load_error !== 1'b1 || load_done !== 1'b0 || cpu_reset !== 1'b1
            || words_loaded !== 16'd0) begin
            failures++;
            $display("FAIL oversize: err=%b done=%b rst=%b words=%0d, want 1 0 1 0",
                     load_error, load_done, cpu_reset, words_loaded);
        end
        for (int i = 0; i < 4; i++) send_byte(8'hAA);
        checks++;
        if (words_loaded !== 16'd0 || load_error !== 1'b1) begin
            failures++;
            $display("FAIL oversize_no_write: words=%0d err=%b, want 0 1",
                     words_loaded, load_error);
        end
    endtask

    task automatic test_exact_depth_count();
        // N == DEPTH is legal; only the count stage is exercised here.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h04);
        checks++;
        if (load_error !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL depth_count_ok: err=%b done=%b, want 0 0", load_error, load_done);
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({load_done, load_error, cpu_reset} !== 3'b100 || words_loaded !== 16'd0) begin
            failures++;
            $display("FAIL empty: done/err/rst=%b%b%b words=%0d, want 100 0",
                     load_done, load_error, cpu_reset, words_loaded);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        load_nominal_words();
        img_q[0] = 32'hA5C3_1E07;
        img_q.push_back(32'h0FF0_8001);
        send_image(5);
        send_byte(exp_sum);
        checks++;
        if (load_done !== 1'b1 || words_loaded !== 16'd3) begin
            failures++;
            $display("FAIL gapped_done: done=%b words=%0d, want 1 3", load_done, words_loaded);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e  = exp_q.pop_front();
            pc = BASE + 32'(4 * i);
            #1;
            checks++;
            if (inst !== e) begin
                failures++;
                $display("FAIL gapped_word%0d: inst=%h, want %h", i, inst, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'h5A);
        // Reset coincides with a valid byte: the byte must be dropped.
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        @(posedge clk_cpu);
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        checks++;
        if (words_loaded !== 16'd0 || load_done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_clear: words=%0d done=%b rst=%b, want 0 0 1",
                     words_loaded, load_done, cpu_reset);
        end
        load_nominal_words();
        send_image(0);
        send_byte(exp_sum);
        checks++;
        if (load_done !== 1'b1 || words_loaded !== 16'd2) begin
            failures++;
            $display("FAIL mid_reset_reload: done=%b words=%0d, want 1 2",
                     load_done, words_loaded);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e  = exp_q.pop_front();
            pc = BASE + 32'(4 * i);
            #1;
            checks++;
            if (inst !== e) begin
                failures++;
                $display("FAIL mid_reset_word%0d: inst=%h, want %h", i, inst, e);
            end
        end
    endtask

    task automatic test_fetch_bounds();
        pc = BASE + 32'(4 * DEPTH);
        #1;
        checks++;
        if (inst !== 32'h0) begin
            failures++;
            $display("FAIL fetch_above: inst=%h, want 00000000", inst);
        end
        pc = BASE - 32'd4;
        #1;
        checks++;
        if (inst !== 32'h0) begin
            failures++;
            $display("FAIL fetch_below: inst=%h, want 00000000", inst);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = BASE;
        test_reset();
        test_nominal();
        test_after_done();
        test_fetch_bounds();
        test_bad_csum();
        test_oversize();
        test_exact_depth_count();
        test_empty();
        test_gapped();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want finish before 500000");
        $fatal(1);
    end

endmodule
